// File: rtl/reorder_logic_pkg.sv
// Shared definitions for the reorder-logic trace path: FSM state encodings,
// width helpers and the default breakpoint marker value.
package reorder_logic_pkg;

    // Value of trace_break_o that marks the final micro-op of an instruction.
    localparam logic BREAKPOINT_DEFAULT = 1'b1;

    // Dispatcher FSM state encodings.
    localparam logic IDLE  = 1'b0;
    localparam logic ISSUE = 1'b1;

    // Selector width for a given number of execution queues (at least 1 bit).
    function automatic int sel_width(input int num_queues);
        return (num_queues > 1) ? $clog2(num_queues) : 1;
    endfunction

    // Instruction ID width for a given reorder depth (at least 1 bit).
    function automatic int id_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trace_dispatcher.sv
// Transmitter side of the reorder-logic trace interface. Accepts whole
// instruction descriptors over valid/ready and serialises them into one trace
// push per micro-op, with the breakpoint and ID push on the last micro-op.
// Optional build macro TRACE_DISPATCHER_DEADLOCK_EN adds a sticky deadlock_o
// flag raised after MAX_STALL consecutive full_i stall cycles.
//
// Handshake: a descriptor transfers on a rising edge where instr_valid_i and
// instr_ready_o are both high; the source must hold the descriptor stable
// while valid is high and ready is low. Trace pushes are single-cycle strobes
// gated by full_i (no push while full_i is high).
module trace_dispatcher
    import reorder_logic_pkg::*;
#(
    parameter int   NUM_QUEUES = 8,
    parameter int   DEPTH      = 64,
    parameter logic BREAKPOINT = BREAKPOINT_DEFAULT,
    parameter int   MAX_MICRO  = 8,
`ifdef TRACE_DISPATCHER_DEADLOCK_EN
    parameter int   MAX_STALL  = 2000,
`endif
    localparam int  SEL_WIDTH  = sel_width(NUM_QUEUES),
    localparam int  ID_WIDTH   = id_width(DEPTH),
    localparam int  LEN_WIDTH  = $clog2(MAX_MICRO + 1)
) (
    input  logic                           clk_i,
    input  logic                           arsn_i,
    input  logic                           instr_valid_i,
    output logic                           instr_ready_o,
    input  logic [ID_WIDTH-1:0]            instr_id_i,
    input  logic [LEN_WIDTH-1:0]           instr_len_i,
    input  logic [MAX_MICRO*SEL_WIDTH-1:0] instr_sels_i,
    input  logic                           full_i,
    output logic                           trace_push_o,
    output logic [SEL_WIDTH-1:0]           trace_sel_o,
    output logic                           trace_break_o,
    output logic                           trace_id_push_o,
    output logic [ID_WIDTH-1:0]            trace_id_value_o,
    output logic                           busy_o,
    output logic                           state_o
`ifdef TRACE_DISPATCHER_DEADLOCK_EN
    ,
    output logic                           deadlock_o
`endif
);

    localparam int IDX_WIDTH = (MAX_MICRO > 1) ? $clog2(MAX_MICRO) : 1;

    logic                           state_q, state_d;
    logic [IDX_WIDTH-1:0]           idx_q;
    logic [LEN_WIDTH-1:0]           len_q;
    logic [ID_WIDTH-1:0]            id_q;
    logic [MAX_MICRO*SEL_WIDTH-1:0] sels_q;

    logic                           in_issue;
    logic                           is_last;
    logic                           push;
    logic                           accept;
    logic [LEN_WIDTH-1:0]           len_clamped;

    assign in_issue = (state_q == ISSUE);
    assign is_last  = in_issue && (LEN_WIDTH'(idx_q) == len_q - LEN_WIDTH'(1));
    assign push     = in_issue && !full_i;
    assign accept   = instr_valid_i && instr_ready_o;
    assign state_o  = state_q;

    // Length normalisation: zero means one micro-op, oversize saturates.
    always_comb begin
        len_clamped = instr_len_i;
        if (instr_len_i == '0) begin
            len_clamped = LEN_WIDTH'(1);
        end else if (instr_len_i > LEN_WIDTH'(MAX_MICRO)) begin
            len_clamped = LEN_WIDTH'(MAX_MICRO);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a handshake on the last push keeps us in ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (push && is_last) state_d = accept ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic, combinational from the latched descriptor and full_i.
    always_comb begin
        instr_ready_o    = arsn_i && (!in_issue || (is_last && !full_i));
        busy_o           = in_issue;
        trace_push_o     = push;
        trace_id_push_o  = push && is_last;
        trace_break_o    = (push && is_last) ? BREAKPOINT : ~BREAKPOINT;
        trace_id_value_o = id_q;
        trace_sel_o      = '0;
        if (in_issue) trace_sel_o = sels_q[int'(idx_q)*SEL_WIDTH +: SEL_WIDTH];
    end

    // Descriptor latch and micro-op index; idx advances only on a non-final push.
    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i) begin
            idx_q  <= '0;
            len_q  <= '0;
            id_q   <= '0;
            sels_q <= '0;
        end else if (accept) begin
            idx_q  <= '0;
            len_q  <= len_clamped;
            id_q   <= instr_id_i;
            sels_q <= instr_sels_i;
        end else if (push && !is_last) begin
            idx_q  <= idx_q + IDX_WIDTH'(1);
        end
    end

`ifdef TRACE_DISPATCHER_DEADLOCK_EN
    localparam int STALL_WIDTH = $clog2(MAX_STALL + 1);

    logic [STALL_WIDTH-1:0] stall_q;
    logic                   deadlock_q;

    assign deadlock_o = deadlock_q;

    // Consecutive stall counter; the flag latches on the MAX_STALL-th stalled cycle.
    always_ff @(posedge clk_i or negedge arsn_i) begin
        if (!arsn_i) begin
            stall_q    <= '0;
            deadlock_q <= 1'b0;
        end else if (in_issue && full_i) begin
            if (stall_q != STALL_WIDTH'(MAX_STALL)) stall_q <= stall_q + STALL_WIDTH'(1);
            if (stall_q == STALL_WIDTH'(MAX_STALL - 1)) deadlock_q <= 1'b1;
        end else begin
            stall_q <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_trace_dispatcher.sv
// Bench for trace_dispatcher: cycle table for directed scenarios, hand
// sequences for reset and stall corners, and a randomized run against a
// queue-based model of expected trace pushes.
module tb_trace_dispatcher;

    localparam int SW = 3;
    localparam int IW = 6;
    localparam int LW = 4;
    localparam int MM = 8;
    localparam int EW = IW + SW + 1;

    logic          clk = 1'b0;
    logic          arsn = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [IW-1:0] instr_id = '0;
    logic [LW-1:0] instr_len = '0;
    logic [MM*SW-1:0] instr_sels = '0;
    logic          full = 1'b0;
    logic          trace_push;
    logic [SW-1:0] trace_sel;
    logic          trace_break;
    logic          trace_id_push;
    logic [IW-1:0] trace_id_value;
    logic          busy;
    logic          state;
`ifdef TRACE_DISPATCHER_DEADLOCK_EN
    logic          deadlock;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trace_dispatcher #(
`ifdef TRACE_DISPATCHER_DEADLOCK_EN
        .MAX_STALL(10)
`endif
    ) dut (
        .clk_i(clk),
        .arsn_i(arsn),
        .instr_valid_i(instr_valid),
        .instr_ready_o(instr_ready),
        .instr_id_i(instr_id),
        .instr_len_i(instr_len),
        .instr_sels_i(instr_sels),
        .full_i(full),
        .trace_push_o(trace_push),
        .trace_sel_o(trace_sel),
        .trace_break_o(trace_break),
        .trace_id_push_o(trace_id_push),
        .trace_id_value_o(trace_id_value),
        .busy_o(busy),
        .state_o(state)
`ifdef TRACE_DISPATCHER_DEADLOCK_EN
        ,
        .deadlock_o(deadlock)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset outputs: ready, push, id push, busy, sel, id value, break (=~BREAKPOINT).
    task automatic check_reset_outputs(input string name);
        check(name, {instr_ready, trace_push, trace_id_push, busy, trace_sel, trace_id_value, trace_break},
              {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0});
    endtask

    typedef struct {
        logic          valid;
        logic [IW-1:0] id;
        logic [LW-1:0] len;
        logic [MM*SW-1:0] sels;
        logic          full;
        logic          ready;
        logic          push;
        logic [SW-1:0] sel;
        logic          brk;
        logic          idp;
        logic [IW-1:0] idval;
        logic          busy;
    } vec_t;

    function automatic vec_t mk(input logic v, input int id, input int len, input int sels, input logic f,
                                input logic r, input logic p, input int sel, input logic b,
                                input logic ip, input int idv, input logic bz);
        vec_t t;
        t.valid = v; t.id = IW'(id); t.len = LW'(len); t.sels = (MM*SW)'(sels); t.full = f;
        t.ready = r; t.push = p; t.sel = SW'(sel); t.brk = b; t.idp = ip; t.idval = IW'(idv); t.busy = bz;
        return t;
    endfunction

    // Model of pending pushes: {id, sel, is_last}, front is the next micro-op.
    logic [EW-1:0] exp_q[$];

    initial begin
        vec_t tbl[23];
        localparam int XS = 24'hFFFFFF;
        // single instruction id5 len3 sels {2,7,0}
        tbl[0]  = mk(1, 5, 3, 184, 0,   1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 63, 7, XS, 0,   0, 1, 0, 0, 0, 5, 1);
        tbl[2]  = mk(0, 63, 7, XS, 0,   0, 1, 7, 0, 0, 5, 1);
        tbl[3]  = mk(0, 63, 7, XS, 0,   1, 1, 2, 1, 1, 5, 1);
        tbl[4]  = mk(0, 63, 7, XS, 0,   1, 0, 0, 0, 0, 5, 0);
        // len 0 then len 1, back-to-back
        tbl[5]  = mk(1, 1, 0, 4, 0,     1, 0, 0, 0, 0, 5, 0);
        tbl[6]  = mk(1, 2, 1, 6, 0,     1, 1, 4, 1, 1, 1, 1);
        tbl[7]  = mk(0, 63, 7, XS, 0,   1, 1, 6, 1, 1, 2, 1);
        tbl[8]  = mk(0, 63, 7, XS, 0,   1, 0, 0, 0, 0, 2, 0);
        // len 4 sels {4,3,2,1} with a 5-cycle stall before the 2nd push
        tbl[9]  = mk(1, 9, 4, 2257, 0,  1, 0, 0, 0, 0, 2, 0);
        tbl[10] = mk(0, 63, 7, XS, 0,   0, 1, 1, 0, 0, 9, 1);
        for (int i = 11; i <= 15; i++) tbl[i] = mk(0, 63, 7, XS, 1, 0, 0, 2, 0, 0, 9, 1);
        tbl[16] = mk(0, 63, 7, XS, 0,   0, 1, 2, 0, 0, 9, 1);
        tbl[17] = mk(0, 63, 7, XS, 0,   0, 1, 3, 0, 0, 9, 1);
        tbl[18] = mk(0, 63, 7, XS, 0,   1, 1, 4, 1, 1, 9, 1);
        // full rising on the last micro-op blocks both pushes together
        tbl[19] = mk(1, 3, 1, 5, 0,     1, 0, 0, 0, 0, 9, 0);
        tbl[20] = mk(0, 63, 7, XS, 1,   0, 0, 5, 0, 0, 3, 1);
        tbl[21] = mk(0, 63, 7, XS, 0,   1, 1, 5, 1, 1, 3, 1);
        tbl[22] = mk(0, 63, 7, XS, 0,   1, 0, 0, 0, 0, 3, 0);

        // Reset then idle
        arsn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            if (i == 3) check_reset_outputs("reset_hold");
        end
        @(negedge clk);
        arsn = 1'b1;
        #2;
        check("idle_after_reset", {instr_ready, trace_push, trace_id_push, busy}, 4'b1000);

        // Directed cycle table
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            instr_valid = tbl[i].valid; instr_id = tbl[i].id; instr_len = tbl[i].len;
            instr_sels = tbl[i].sels; full = tbl[i].full;
            #2;
            check($sformatf("tbl[%0d] rdy/push/brk/idp/busy", i),
                  {instr_ready, trace_push, trace_break, trace_id_push, busy},
                  {tbl[i].ready, tbl[i].push, tbl[i].brk, tbl[i].idp, tbl[i].busy});
            if (tbl[i].busy)
                check($sformatf("tbl[%0d] sel/idval", i), {trace_sel, trace_id_value}, {tbl[i].sel, tbl[i].idval});
        end

        // Mid-instruction reset
        @(negedge clk);
        instr_valid = 1'b1; instr_id = 6'd7; instr_len = 4'd8; instr_sels = 24'hFAC688; full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            #2;
            check($sformatf("midrst push%0d", i), {trace_push, trace_id_push, busy}, 3'b101);
        end
        @(negedge clk);
        arsn = 1'b0;
        #1;
        check_reset_outputs("midrst_immediate");
        @(negedge clk);
        arsn = 1'b1;
        #2;
        check("midrst_release", {instr_ready, trace_push, busy}, 3'b100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            check("midrst_no_stale", {trace_push, trace_id_push, busy}, 3'b000);
        end

        // Randomized run against the queue model
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            logic exp_ready, exp_push, exp_busy;
            @(negedge clk);
            instr_valid = ($urandom_range(0, 1) == 1);
            instr_id    = IW'($urandom);
            instr_len   = LW'($urandom_range(0, 15));
            instr_sels  = (MM*SW)'($urandom);
            full        = ($urandom_range(0, 3) == 0);
            #2;
            exp_busy  = (exp_q.size() != 0);
            exp_push  = exp_busy && !full;
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && !full);
            check("rand rdy/push/busy", {instr_ready, trace_push, busy}, {exp_ready, exp_push, exp_busy});
            if (exp_push) begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("rand sel/brk/idp/id", {trace_sel, trace_break, trace_id_push, trace_id_value},
                      {e[SW:1], e[0], e[0], e[EW-1:SW+1]});
            end
            if (instr_valid && exp_ready) begin
                int n;
                n = (instr_len == 0) ? 1 : ((instr_len > MM) ? MM : int'(instr_len));
                for (int k = 0; k < n; k++)
                    exp_q.push_back({instr_id, instr_sels[k*SW +: SW], (k == n - 1)});
            end
        end
        // Drain with a bounded budget
        begin
            int budget;
            budget = 0;
            while (exp_q.size() != 0 && budget < 100) begin
                logic [EW-1:0] e;
                @(negedge clk);
                instr_valid = 1'b0; full = 1'b0;
                #2;
                e = exp_q.pop_front();
                check("drain push/sel/brk/idp/id", {trace_push, trace_sel, trace_break, trace_id_push, trace_id_value},
                      {1'b1, e[SW:1], e[0], e[0], e[EW-1:SW+1]});
                budget++;
            end
            check("drain_complete", 64'(exp_q.size()), 64'd0);
            @(negedge clk); #2;
            check("drain_idle", {instr_ready, busy}, 2'b10);
        end

`ifdef TRACE_DISPATCHER_DEADLOCK_EN
        // Deadlock flag after 10 consecutive stalled cycles, sticky afterwards
        @(negedge clk);
        arsn = 1'b0;
        @(negedge clk);
        arsn = 1'b1;
        #2;
        check("deadlock_after_reset", 64'(deadlock), 64'd0);
        @(negedge clk);
        instr_valid = 1'b1; instr_id = 6'd4; instr_len = 4'd2; instr_sels = 24'd3; full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr_valid = 1'b0; full = 1'b1;
            #2;
            check($sformatf("deadlock_low_stall%0d", i), {64'(deadlock)}, 64'd0);
        end
        @(negedge clk);
        full = 1'b0;
        #2;
        check("deadlock_set", {deadlock, trace_push, trace_sel}, {1'b1, 1'b1, 3'd3});
        @(negedge clk); #2;
        check("deadlock_dispatch_continues", {deadlock, trace_push, trace_id_push}, 3'b111);
        @(negedge clk); #2;
        check("deadlock_sticky", {deadlock, busy}, 2'b10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
